// File: rtl/ro_monitor_pkg.sv
// Shared types and constants for the ring-oscillator monitor controller.
package ro_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int WIN_SEL_W = 3;
  localparam int WIN_BASE  = 16;
  localparam int WIN_CNT_W = 11;

  // Terminal-count load for a window of (WIN_BASE << sel) cycles; 2048 loads as 2047.
  function automatic logic [WIN_CNT_W-1:0] win_load(input logic [WIN_SEL_W-1:0] sel);
    logic [WIN_CNT_W:0] n;
    n = (WIN_CNT_W+1)'(WIN_BASE) << sel;
    n = n - (WIN_CNT_W+1)'(1);
    return n[WIN_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ro_monitor_sync_edge.sv
// Two-flop synchroniser for the divided RO output plus a third flop for rising-edge detect.
module ro_monitor_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], async_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/ro_monitor_ctrl.sv
// Ring-oscillator speed monitor: enable ring, settle, count divided-RO edges over a window.
//
// state   | meaning
// IDLE    | ring off, no result
// SETTLE  | ring on, waiting SETTLE_CYC cycles for it to stabilise
// MEASURE | ring on, counting synchronised rising edges for N cycles
// DONE    | ring off, COUNT/OVF hold a valid result
module ro_monitor_ctrl
  import ro_monitor_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16
) (
`ifdef USE_POWER_PINS
  inout  wire               VDD,
  inout  wire               VSS,
`endif
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [WIN_SEL_W-1:0] WIN_SEL,
  input  logic                 RO_DIV,
  output logic                 RO_EN,
  output logic                 BUSY,
  output logic                 VALID,
  output logic                 OVF,
  output logic [CNT_W-1:0]     COUNT
);

  localparam logic [WIN_CNT_W-1:0] SETTLE_LOAD = WIN_CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX     = '1;

  state_e               state_q, state_d;
  logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_SEL_W-1:0] win_sel_q, win_sel_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 tick;

  ro_monitor_sync_edge u_sync (
    .clk      (CLK),
    .rst      (RST),
    .async_in (RO_DIV),
    .rise     (tick)
  );

  // The same down-counter times the settle phase and then the measurement window.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    win_sel_d = win_sel_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (START) begin
          state_d   = SETTLE;
          win_sel_d = WIN_SEL;
          win_cnt_d = SETTLE_LOAD;
          count_d   = '0;
          ovf_d     = 1'b0;
        end
      end
      SETTLE: begin
        if (win_cnt_q == '0) begin
          state_d   = MEASURE;
          win_cnt_d = win_load(win_sel_q);
        end else begin
          win_cnt_d = win_cnt_q - WIN_CNT_W'(1);
        end
      end
      MEASURE: begin
        if (tick) begin
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + CNT_W'(1);
        end
        if (win_cnt_q == '0) state_d = DONE;
        else                 win_cnt_d = win_cnt_q - WIN_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a START in the same cycle.
    if (STOP) begin
      state_d   = IDLE;
      win_cnt_d = win_cnt_q;
      win_sel_d = win_sel_q;
      count_d   = count_q;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      win_sel_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      win_sel_q <= win_sel_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign RO_EN = (state_q == SETTLE) || (state_q == MEASURE);
  assign BUSY  = RO_EN;
  assign VALID = (state_q == DONE);
  assign OVF   = ovf_q;
  assign COUNT = count_q;

endmodule
